// File: rtl/xgmii_tx_scrambler.sv
// xgmii_tx_scrambler: self-synchronous 64b/66b scrambler, x^58 + x^39 + 1, on 32-bit words.
// Two words form one 66b block; the 2-bit sync header is carried alongside, unscrambled.
// The datapath is an output register backed by a one-entry skid buffer, so the
// ready returned to the encoder can be a flop.
// Optional build macro SCRAMBLER_BYPASS_EN adds i_bypass, which forwards words
// unscrambled and freezes the scrambler state.

module xgmii_tx_scrambler_chk (
    input  logic i_clk,
    input  logic i_reset,
    input  logic out_valid,
    input  logic skid_valid
);

    // The skid entry may only ever be occupied behind a valid output register.
    a_skid_behind_out: assert property (@(posedge i_clk) disable iff (i_reset)
        !(skid_valid && !out_valid));

endmodule

module xgmii_tx_scrambler #(
    parameter int          DATA_WIDTH = 32,
    parameter int          HDR_WIDTH  = 2,
    parameter logic [57:0] SCR_INIT   = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic                  i_bypass,
`endif
    input  logic [DATA_WIDTH-1:0] i_encoded_data,
    input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
    input  logic                  i_data_valid,
    output logic                  o_scrambler_trdy,
    output logic [DATA_WIDTH-1:0] o_scr_data,
    output logic [HDR_WIDTH-1:0]  o_scr_hdr,
    output logic                  o_scr_hdr_valid,
    output logic                  o_scr_valid,
    input  logic                  i_gearbox_trdy,
    output logic                  o_hdr_err
);

    // HIST: depth of the scrambled-bit history; TAP: position of the x^39 tap
    // inside the extended {word, history} vector (58 - 39).
    localparam int HIST   = 58;
    localparam int TAP    = 19;
    // Pipeline word layout: {hdr_valid, hdr, data}
    localparam int WORD_W = DATA_WIDTH + HDR_WIDTH + 1;

    // Advance the scrambler by one word. The history vector is extended by the
    // new word so that taps falling inside the current word (bit i >= 39) chain
    // naturally. Bit k of the returned state is the scrambled bit emitted
    // (58 - k) bits ago, so the new word sits in the top DATA_WIDTH bits.
    function automatic logic [HIST-1:0] scr_advance(
        input logic [DATA_WIDTH-1:0] x,
        input logic [HIST-1:0]       s
    );
        logic [HIST+DATA_WIDTH-1:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, s};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ext[HIST + i] = x[i] ^ ext[TAP + i] ^ ext[i];
        end
        return ext[HIST+DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    logic                  bypass_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;
    logic [HIST-1:0]       state_next_s;
    logic [DATA_WIDTH-1:0] word_data_s;
    logic [HDR_WIDTH-1:0]  word_hdr_s;
    logic                  word_err_s;
    logic [WORD_W-1:0]     word_s;

    logic                  out_load_in_s;
    logic                  out_load_skid_s;
    logic                  skid_load_s;
    logic                  out_valid_nxt_s;
    logic                  skid_valid_nxt_s;

    logic [HIST-1:0]       state_r;
    logic                  phase_r;
    logic [HDR_WIDTH-1:0]  hdr_latch_r;
    logic [WORD_W-1:0]     out_word_r;
    logic                  out_valid_r;
    logic [WORD_W-1:0]     skid_word_r;
    logic                  skid_valid_r;
    logic                  skid_err_r;
    logic                  err_pulse_r;
    logic                  trdy_r;

`ifdef SCRAMBLER_BYPASS_EN
    assign bypass_s = i_bypass;
`else
    assign bypass_s = 1'b0;
`endif

    assign in_xfer_s  = i_data_valid & trdy_r;
    assign out_xfer_s = out_valid_r & i_gearbox_trdy;

    // Scrambled word and its block tags as they would enter the pipeline this cycle
    always_comb begin
        state_next_s = scr_advance(i_encoded_data, state_r);
        if (bypass_s) begin
            word_data_s = i_encoded_data;
        end else begin
            word_data_s = state_next_s[HIST-1 -: DATA_WIDTH];
        end
        if (phase_r) begin
            word_hdr_s = hdr_latch_r;
            word_err_s = 1'b0;
        end else begin
            word_hdr_s = i_sync_hdr;
            word_err_s = (i_sync_hdr == {HDR_WIDTH{1'b0}}) ||
                         (i_sync_hdr == {HDR_WIDTH{1'b1}});
        end
        word_s = {~phase_r, word_hdr_s, word_data_s};
    end

    // Output register / skid buffer steering
    always_comb begin
        out_load_in_s    = 1'b0;
        out_load_skid_s  = 1'b0;
        skid_load_s      = 1'b0;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (skid_valid_r) begin
            // Ready is low while the skid is full, so no input can arrive here.
            if (out_xfer_s) begin
                out_load_skid_s  = 1'b1;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s  = 1'b1;
            end
        end else if (!out_valid_r || out_xfer_s) begin
            // Output slot free (or freeing this cycle): reload with no bubble.
            if (in_xfer_s) begin
                out_load_in_s   = 1'b1;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            // Output stalled: park an arriving word in the skid entry.
            if (in_xfer_s) begin
                skid_load_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = 1'b0;
            end
        end
    end

    // Scrambler state, block phase and latched header advance on input transfers only
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= SCR_INIT;
            phase_r     <= 1'b0;
            hdr_latch_r <= {HDR_WIDTH{1'b0}};
        end else if (in_xfer_s) begin
            phase_r <= ~phase_r;
            if (!bypass_s) begin
                state_r <= state_next_s;
            end
            if (!phase_r) begin
                hdr_latch_r <= i_sync_hdr;
            end
        end
    end

    // Output register, skid entry, ready flop and header-error pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_word_r   <= {WORD_W{1'b0}};
            out_valid_r  <= 1'b0;
            skid_word_r  <= {WORD_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_err_r   <= 1'b0;
            err_pulse_r  <= 1'b0;
            trdy_r       <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            trdy_r       <= ~skid_valid_nxt_s;
            // The error flag only lives for the first cycle a word is presented.
            err_pulse_r  <= (out_load_in_s & word_err_s) | (out_load_skid_s & skid_err_r);
            if (out_load_skid_s) begin
                out_word_r <= skid_word_r;
            end else if (out_load_in_s) begin
                out_word_r <= word_s;
            end
            if (skid_load_s) begin
                skid_word_r <= word_s;
                skid_err_r  <= word_err_s;
            end
        end
    end

    assign o_scr_data       = out_word_r[DATA_WIDTH-1:0];
    assign o_scr_hdr        = out_word_r[DATA_WIDTH +: HDR_WIDTH];
    assign o_scr_hdr_valid  = out_word_r[WORD_W-1];
    assign o_scr_valid      = out_valid_r;
    assign o_scrambler_trdy = trdy_r;
    assign o_hdr_err        = err_pulse_r;

    xgmii_tx_scrambler_chk u_chk (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .out_valid  (out_valid_r),
        .skid_valid (skid_valid_r)
    );

endmodule

// File: tb/tb_xgmii_tx_scrambler.sv
// Testbench for xgmii_tx_scrambler: table of directed words, random streaming
// with a stalling gearbox, mid-block reset and (with SCRAMBLER_BYPASS_EN) bypass.
// Expected words come from a bit-serial scrambler model via a scoreboard queue;
// transferred words are also run through a bit-serial descrambler.

module tb_xgmii_tx_scrambler;

    logic        clk            = 1'b0;
    logic        i_reset        = 1'b1;
    logic [31:0] i_encoded_data = 32'h0;
    logic [1:0]  i_sync_hdr     = 2'b00;
    logic        i_data_valid   = 1'b0;
    logic        i_gearbox_trdy = 1'b0;
    logic        byp            = 1'b0;

    logic        o_scrambler_trdy;
    logic [31:0] o_scr_data;
    logic [1:0]  o_scr_hdr;
    logic        o_scr_hdr_valid;
    logic        o_scr_valid;
    logic        o_hdr_err;

    always #5 clk = ~clk;

    xgmii_tx_scrambler u_dut (
`ifdef SCRAMBLER_BYPASS_EN
        .i_bypass         (byp),
`endif
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_encoded_data   (i_encoded_data),
        .i_sync_hdr       (i_sync_hdr),
        .i_data_valid     (i_data_valid),
        .o_scrambler_trdy (o_scrambler_trdy),
        .o_scr_data       (o_scr_data),
        .o_scr_hdr        (o_scr_hdr),
        .o_scr_hdr_valid  (o_scr_hdr_valid),
        .o_scr_valid      (o_scr_valid),
        .i_gearbox_trdy   (i_gearbox_trdy),
        .o_hdr_err        (o_hdr_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] orig;
        logic [1:0]  hdr;
        logic        hv;
        logic        err;
        logic        byp;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  h;
        logic        g;
        logic        ue;
        logic [31:0] ed;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[8];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state: serial scrambler/descrambler histories, bit 0 = newest.
    logic [57:0] sr  = {58{1'b1}};
    logic [57:0] dsr = {58{1'b1}};
    logic        ph  = 1'b0;
    logic [1:0]  hl  = 2'b00;
    logic        prev_valid = 1'b0;
    logic        prev_xfer  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_scramble(input logic [31:0] x, output logic [31:0] y);
        logic b;
        for (int i = 0; i < 32; i++) begin
            b    = x[i] ^ sr[38] ^ sr[57];
            y[i] = b;
            sr   = {sr[56:0], b};
        end
    endtask

    task automatic model_descramble(input logic [31:0] y, output logic [31:0] x);
        for (int i = 0; i < 32; i++) begin
            x[i] = y[i] ^ dsr[38] ^ dsr[57];
            dsr  = {dsr[56:0], y[i]};
        end
    endtask

    task automatic model_reset();
        sr         = {58{1'b1}};
        dsr        = {58{1'b1}};
        ph         = 1'b0;
        hl         = 2'b00;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        q.delete();
    endtask

    // One clock: drive inputs on the falling edge, check the presented output,
    // and push the expected word for any input transfer the coming edge makes.
    task automatic step(input logic [31:0] d, input logic [1:0] h, input logic v,
                        input logic g, input logic ue, input logic [31:0] ed,
                        output logic acc);
        exp_t        e;
        logic [31:0] y;
        logic [31:0] x;
        logic        fresh;
        @(negedge clk);
        i_encoded_data = d;
        i_sync_hdr     = h;
        i_data_valid   = v;
        i_gearbox_trdy = g;
        fresh = !prev_valid || prev_xfer;
        if (o_scr_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h, want no word", o_scr_data);
            end else begin
                e = q[0];
                chk("scr_data",  64'(o_scr_data), 64'(e.data));
                chk("scr_hdr",   64'(o_scr_hdr), 64'(e.hdr));
                chk("hdr_valid", 64'(o_scr_hdr_valid), 64'(e.hv));
                chk("hdr_err",   64'(o_hdr_err), 64'(fresh ? e.err : 1'b0));
                if (g) begin
                    void'(q.pop_front());
                    if (!e.byp) begin
                        model_descramble(o_scr_data, x);
                        chk("descrambled", 64'(x), 64'(e.orig));
                    end
                end
            end
        end else begin
            chk("hdr_err_idle", 64'(o_hdr_err), 64'd0);
        end
        prev_valid = o_scr_valid;
        prev_xfer  = o_scr_valid && g;
        acc = v && o_scrambler_trdy;
        if (acc) begin
            if (byp) begin
                y = d;
            end else begin
                model_scramble(d, y);
            end
            e.data = ue ? ed : y;
            e.orig = d;
            e.hdr  = ph ? hl : h;
            e.hv   = !ph;
            e.err  = !ph && (h == 2'b00 || h == 2'b11);
            e.byp  = byp;
            if (!ph) hl = h;
            ph = !ph;
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] h, input logic g,
                        input logic ue, input logic [31:0] ed);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(d, h, 1'b1, g, ue, ed, acc);
            n++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got trdy stuck low, want word accepted");
        end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((q.size() != 0 || o_scr_valid) && n < 50) begin
            step(32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0, acc);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic align_block();
        if (ph) send($urandom, 2'b10, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("trdy_after_release", 64'(o_scrambler_trdy), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},     64'(o_scr_valid), 64'd0);
        chk({tag, "_hdr_valid"}, 64'(o_scr_hdr_valid), 64'd0);
        chk({tag, "_hdr_err"},   64'(o_hdr_err), 64'd0);
        chk({tag, "_data"},      64'(o_scr_data), 64'd0);
        chk({tag, "_hdr"},       64'(o_scr_hdr), 64'd0);
        chk({tag, "_trdy"},      64'(o_scrambler_trdy), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic        acc;
        logic [31:0] d;
        logic [1:0]  h;
        int          r;
        int          words;
        int          cyc;

        tbl[0] = '{32'h0000_0000, 2'b01, 1'b1, 1'b1, 32'h0000_0000};
        tbl[1] = '{32'h0000_0000, 2'b01, 1'b1, 1'b1, 32'h03FF_FF80};
        tbl[2] = '{32'h1234_5678, 2'b10, 1'b1, 1'b0, 32'h0};
        tbl[3] = '{32'h9ABC_DEF0, 2'b10, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{32'h0000_0000, 2'b11, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{32'hFFFF_FFFF, 2'b00, 1'b1, 1'b0, 32'h0};
        tbl[6] = '{32'hA5A5_A5A5, 2'b00, 1'b1, 1'b0, 32'h0};
        tbl[7] = '{32'h5A5A_5A5A, 2'b01, 1'b1, 1'b0, 32'h0};

        // Reset state
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        release_reset();

        // Directed table: known-answer words, header errors, a stalled row
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].d, tbl[i].h, tbl[i].g, tbl[i].ue, tbl[i].ed);
        end
        drain();

        // Random stream, gearbox ready about 30% of cycles
        words = 0;
        cyc   = 0;
        while (words < 1000 && cyc < 20000) begin
            d = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)      h = 2'b11;
            else if (r < 5)  h = 2'b01;
            else             h = 2'b10;
            step(d, h, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 30),
                 1'b0, 32'h0, acc);
            if (acc) words++;
            cyc++;
        end
        chk("random_words_accepted", 64'(words), 64'd1000);
        drain();

        // Stall: gearbox low for 5 cycles while the encoder keeps offering words
        for (int k = 0; k < 4; k++) begin
            step($urandom, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, acc);
        end
        for (int k = 0; k < 5; k++) begin
            step($urandom, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0, acc);
            if (k == 2) chk("trdy_stalled", 64'(o_scrambler_trdy), 64'd0);
        end
        for (int k = 0; k < 6; k++) begin
            step($urandom, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, acc);
        end
        drain();

        // Reset after the first word of a block
        align_block();
        drain();
        send(32'hCAFE_F00D, 2'b01, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(o_scr_valid), 64'd1);
        i_reset = 1'b1;
        #1;
        check_reset_outputs("midblock");
        model_reset();
        release_reset();
        send(tbl[0].d, tbl[0].h, 1'b1, 1'b1, tbl[0].ed);
        send(tbl[1].d, tbl[1].h, 1'b1, 1'b1, tbl[1].ed);
        drain();

`ifdef SCRAMBLER_BYPASS_EN
        // Bypass one block, then confirm scrambling resumes from the frozen state
        send(32'h1111_2222, 2'b10, 1'b1, 1'b0, 32'h0);
        send(32'h3333_4444, 2'b10, 1'b1, 1'b0, 32'h0);
        align_block();
        byp = 1'b1;
        send(32'hDEAD_BEEF, 2'b01, 1'b1, 1'b1, 32'hDEAD_BEEF);
        send(32'h0123_4567, 2'b01, 1'b1, 1'b0, 32'h0);
        drain();
        byp = 1'b0;
        send(32'h89AB_CDEF, 2'b10, 1'b1, 1'b0, 32'h0);
        send(32'h7654_3210, 2'b10, 1'b1, 1'b0, 32'h0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
